// File: rtl/sram_like_pkg.sv
// -----------------------------------------------------------------------------
// sram_like_pkg
// Shared definitions for the SRAM-like data responder.
//   SZ_*               : data_size encodings (byte / halfword / word)
//   req_entry_t        : one queued request {wr, size, addr, wdata}, 67 bits
//   strb_result_t      : byte-lane strobe plus an illegal-request flag
//   size_addr_to_strb  : maps size and addr[1:0] to lane strobes and flags
//                        illegal size/alignment combinations
// -----------------------------------------------------------------------------
package sram_like_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_entry_t;

    typedef struct packed {
        logic [3:0] strb;
        logic       illegal;
    } strb_result_t;

    // An illegal request yields an all-zero strobe so it can never touch memory.
    function automatic strb_result_t size_addr_to_strb(input logic [1:0] size,
                                                       input logic [1:0] addr_lo);
        strb_result_t r;
        r.strb    = 4'b0000;
        r.illegal = 1'b0;
        case (size)
            SZ_BYTE: r.strb = 4'b0001 << addr_lo;
            SZ_HALF: begin
                if (addr_lo[0]) r.illegal = 1'b1;
                else            r.strb    = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                if (addr_lo != 2'b00) r.illegal = 1'b1;
                else                  r.strb    = 4'b1111;
            end
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/resp_req_fifo.sv
// -----------------------------------------------------------------------------
// resp_req_fifo
// Synchronous DEPTH-entry FIFO of request entries, first-word-fall-through:
// head always shows the oldest entry while empty is low.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data this edge (ignored when full)
//   push_data  : entry to enqueue
//   pop        : drop the head entry this edge (ignored when empty)
//   head       : oldest entry, valid while empty is low
//   count      : number of stored entries (0..DEPTH)
//   full/empty : status flags derived from count
// -----------------------------------------------------------------------------
module resp_req_fifo
    import sram_like_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  req_entry_t             push_data,
    input  logic                   pop,
    output req_entry_t             head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    req_entry_t    slots [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = slots[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sram_like_responder.sv
// -----------------------------------------------------------------------------
// sram_like_responder
// Responder end of the SRAM-like data interface. Queues up to DEPTH accepted
// requests, completes them strictly in acceptance order, one per LAT cycles
// of head occupancy, against a byte-writable memory of 2^ADDR_BITS words.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   data_req      : master request valid
//   data_wr       : 1 = write, 0 = read
//   data_size     : 0 byte, 1 halfword, 2 word
//   data_addr     : byte address (word index = addr[ADDR_BITS+1:2])
//   data_wdata    : write data, lane-aligned to the address
//   data_addr_ok  : request accepted this cycle
//   data_rdata    : aligned read word during a read's data_ok, else 0
//   data_data_ok  : completion pulse, one per accepted request
//   busy          : back-pressure, forces data_addr_ok low
//   err           : sticky flag for illegal size / misaligned access
//
// Handshake: a request transfers at the rising edge where data_req and
// data_addr_ok are both high; {wr,size,addr,wdata} are sampled only then.
// data_addr_ok depends on the current occupancy only, never on a same-cycle
// completion, so a full queue refuses even in the cycle it pops. Each
// accepted request later produces exactly one data_data_ok cycle, in order;
// the master has no ready for completions and must take them when offered.
// -----------------------------------------------------------------------------
module sram_like_responder
    import sram_like_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int DEPTH     = 4,
    parameter int LAT       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic [31:0] data_rdata,
    output logic        data_data_ok,
    input  logic        busy,
    output logic        err
);

    localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int QC_W  = $clog2(DEPTH) + 1;

    req_entry_t             push_data;
    req_entry_t             head;
    logic [QC_W-1:0]        count;
    logic                   full;
    logic                   empty;
    logic [CNT_W-1:0]       cnt;
    logic                   fire;
    logic [ADDR_BITS-1:0]   idx;
    strb_result_t           lanes;
    logic [31:0]            mem [2**ADDR_BITS];
    logic                   unused_bits;

    assign push_data = '{wr: data_wr, size: data_size, addr: data_addr, wdata: data_wdata};

    // Outputs are held quiet while reset is asserted so nothing leaks out of
    // the queue being discarded.
    assign data_addr_ok = !rst && data_req && !busy && (count < QC_W'(DEPTH));

    resp_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (data_addr_ok),
        .push_data (push_data),
        .pop       (fire),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Head counter: counts cycles the head entry has been waiting; the
    // entry completes in the cycle the count reaches LAT-1.
    assign fire = !rst && !empty && (cnt == CNT_W'(LAT - 1));

    always_ff @(posedge clk) begin
        if (rst)         cnt <= '0;
        else if (fire)   cnt <= '0;
        else if (!empty) cnt <= cnt + 1'b1;
    end

    // Upper address bits alias onto the same words.
    assign idx   = head.addr[ADDR_BITS+1:2];
    assign lanes = size_addr_to_strb(head.size, head.addr[1:0]);

    assign data_data_ok = fire;
    assign data_rdata   = (fire && !head.wr) ? mem[idx] : 32'd0;

    // Write lands at the edge closing the data_ok cycle, so a later read of
    // the same word (queued behind it) sees the new data.
    always_ff @(posedge clk) begin
        if (fire && head.wr) begin
            for (int b = 0; b < 4; b++) begin
                if (lanes.strb[b]) mem[idx][8*b +: 8] <= head.wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                        err <= 1'b0;
        else if (fire && lanes.illegal) err <= 1'b1;
    end

    assign unused_bits = ^{full, head.addr[31:ADDR_BITS+2]};

endmodule

// File: tb/tb_sram_like_responder.sv
// -----------------------------------------------------------------------------
// tb_sram_like_responder
// Two responders share the request fields: u_lat1 (LAT=1) and u_lat4 (LAT=4),
// both DEPTH=4. sel picks which one gets data_req and whose outputs the
// generic helpers look at. Inputs change 1 time unit after a rising edge;
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sram_like_responder;

    logic        clk;
    logic        rst;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    int          sel;

    logic        req1, aok1, dok1, err1;
    logic [31:0] rdata1;
    logic        req4, aok4, dok4, err4;
    logic [31:0] rdata4;

    logic        aok, dok, errs;
    logic [31:0] rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];

    assign req1  = req && (sel == 1);
    assign req4  = req && (sel == 4);
    assign aok   = (sel == 4) ? aok4   : aok1;
    assign dok   = (sel == 4) ? dok4   : dok1;
    assign rdata = (sel == 4) ? rdata4 : rdata1;
    assign errs  = (sel == 4) ? err4   : err1;

    sram_like_responder #(.ADDR_BITS(10), .DEPTH(4), .LAT(1)) u_lat1 (
        .clk          (clk),
        .rst          (rst),
        .data_req     (req1),
        .data_wr      (wr),
        .data_size    (size),
        .data_addr    (addr),
        .data_wdata   (wdata),
        .data_addr_ok (aok1),
        .data_rdata   (rdata1),
        .data_data_ok (dok1),
        .busy         (busy),
        .err          (err1)
    );

    sram_like_responder #(.ADDR_BITS(10), .DEPTH(4), .LAT(4)) u_lat4 (
        .clk          (clk),
        .rst          (rst),
        .data_req     (req4),
        .data_wr      (wr),
        .data_size    (size),
        .data_addr    (addr),
        .data_wdata   (wdata),
        .data_addr_ok (aok4),
        .data_rdata   (rdata4),
        .data_data_ok (dok4),
        .busy         (busy),
        .err          (err4)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver: one request on the selected responder. Waits (bounded) for
    // acceptance, then for its data_ok; returns rdata and the number of
    // cycles from the accept cycle to data_ok. Ends on the data_ok cycle.
    task automatic xact(input logic w, input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output int lat);
        int n;
        cyc();
        wr = w; size = s; addr = a; wdata = d; req = 1'b1;
        #4;
        n = 0;
        while (!aok && n < 20) begin
            cyc(); #4; n++;
        end
        chk_bit("xact_accept", aok, 1'b1);
        cyc();
        req = 1'b0;
        #4;
        lat = 1;
        while (!dok && lat < 40) begin
            cyc(); #4; lat++;
        end
        chk_bit("xact_data_ok", dok, 1'b1);
        rd = rdata;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] rd;
        int          lat;
        logic        exp_aok;
        logic        exp_dok;

        rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = '0; wdata = '0;
        busy = 1'b0; sel = 1;
        cyc(); cyc(); cyc();
        rst = 1'b0;
        #4;
        chk_bit ("reset_aok1",  aok1,   1'b0);
        chk_bit ("reset_dok1",  dok1,   1'b0);
        chk_word("reset_rd1",   rdata1, 32'd0);
        chk_bit ("reset_err1",  err1,   1'b0);
        chk_bit ("reset_dok4",  dok4,   1'b0);
        chk_word("reset_rd4",   rdata4, 32'd0);
        chk_bit ("reset_err4",  err4,   1'b0);

        // LAT=1: back-to-back write then read of the same word.
        sel = 1;
        cyc();
        req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h100; wdata = 32'hDEADBEEF;
        #4;
        chk_bit("b2b_aok_wr", aok, 1'b1);
        chk_bit("b2b_dok_c0", dok, 1'b0);
        cyc();
        wr = 1'b0; wdata = 32'h0;
        #4;
        chk_bit("b2b_aok_rd", aok, 1'b1);
        chk_bit("b2b_dok_wr", dok, 1'b1);
        cyc();
        req = 1'b0;
        #4;
        chk_bit ("b2b_dok_rd",   dok,   1'b1);
        chk_word("b2b_rdata",    rdata, 32'hDEADBEEF);
        cyc(); #4;
        chk_bit("b2b_dok_idle", dok, 1'b0);

        // Byte and halfword lane writes.
        xact(1'b1, 2'd2, 32'h100, 32'h11223344, rd, lat);
        chk_bit("lat1_latency", (lat == 1), 1'b1);
        xact(1'b1, 2'd0, 32'h101, 32'h0000AA00, rd, lat);
        xact(1'b0, 2'd2, 32'h100, 32'h0, rd, lat);
        chk_word("byte_merge", rd, 32'h1122AA44);
        xact(1'b1, 2'd1, 32'h102, 32'h55660000, rd, lat);
        xact(1'b0, 2'd2, 32'h100, 32'h0, rd, lat);
        chk_word("half_merge", rd, 32'h5566AA44);

        // busy holds addr_ok low; accepted on the first free cycle.
        for (int i = 0; i < 3; i++) begin
            cyc();
            busy = 1'b1; req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h100;
            #4;
            chk_bit("busy_aok_low", aok, 1'b0);
        end
        cyc();
        busy = 1'b0;
        #4;
        chk_bit("busy_release_aok", aok, 1'b1);
        cyc();
        req = 1'b0;
        #4;
        chk_bit ("busy_dok",   dok,   1'b1);
        chk_word("busy_rdata", rdata, 32'h5566AA44);

        // Misaligned halfword write: completes, no memory change, sticky err.
        chk_bit("err_before", errs, 1'b0);
        xact(1'b1, 2'd1, 32'h103, 32'hFFFF0000, rd, lat);
        cyc(); #4;
        chk_bit("err_set", errs, 1'b1);
        xact(1'b0, 2'd2, 32'h100, 32'h0, rd, lat);
        chk_word("misaligned_nowrite", rd, 32'h5566AA44);
        // size=3 read still returns the aligned word.
        xact(1'b0, 2'd3, 32'h101, 32'h0, rd, lat);
        chk_word("size3_read", rd, 32'h5566AA44);
        cyc(); #4;
        chk_bit("err_sticky", errs, 1'b1);

        // LAT=4: preload words 0..5 at byte addresses 0,4,...,20.
        sel = 4;
        for (int k = 0; k < 6; k++) begin
            xact(1'b1, 2'd2, 32'(4 * k), 32'hA0000000 | 32'(k), rd, lat);
            if (k == 0) chk_bit("lat4_latency", (lat == 4), 1'b1);
        end

        // Hold req six cycles (addr 4k in cycle k). Four accepts fill the
        // queue; cycle 4 is the first pop and still refuses; cycle 5 accepts.
        // Completions land every 4 cycles: 4, 8, 12, 16, 20.
        for (int k = 0; k < 24; k++) begin
            cyc();
            req = (k < 6); wr = 1'b0; size = 2'd2; addr = 32'(4 * k); wdata = 32'h0;
            exp_aok = (k < 4) || (k == 5);
            exp_dok = (k == 4) || (k == 8) || (k == 12) || (k == 16) || (k == 20);
            if (exp_aok) exp_q.push_back(32'hA0000000 | 32'(k));
            #4;
            chk_bit("full_aok", aok, exp_aok);
            chk_bit("full_dok", dok, exp_dok);
            if (exp_dok) chk_word("full_order_rdata", rdata, exp_q.pop_front());
        end
        chk_bit("full_q_drained", (exp_q.size() == 0), 1'b1);

        // Reset with three reads outstanding: none of them completes.
        for (int k = 0; k < 11; k++) begin
            cyc();
            req = (k < 3); wr = 1'b0; size = 2'd2; addr = 32'(4 * k);
            rst = (k == 3);
            #4;
            chk_bit("rst_no_dok", dok, 1'b0);
        end
        chk_bit("rst_clears_err", err1, 1'b0);

        // Queue is empty and head counter cleared: fresh read takes LAT cycles.
        cyc();
        req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h8;
        #4;
        chk_bit("post_rst_aok", aok, 1'b1);
        for (int j = 1; j <= 4; j++) begin
            cyc();
            req = 1'b0;
            #4;
            chk_bit("post_rst_dok", dok, (j == 4));
            if (j == 4) chk_word("post_rst_rdata", rdata, 32'hA0000002);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_like_responder.md
Name: sram_like_responder

Overview:
- Slave (responder) end of the SRAM-like data interface (req/wr/size/addr/wdata, addr_ok/data_ok/rdata) that the MEM-stage data master drives.
- Accepts up to DEPTH outstanding requests, completes them strictly in order after a programmable latency, and backs them with an on-chip byte-writable word memory.
- Used as the uncached-data target in the SoC-lite test harness and as the bus model for verifying the data master.

Parameters:
- ADDR_BITS, 10, word-index width; memory holds 2^ADDR_BITS 32-bit words.
- DEPTH, 4, outstanding-request queue depth (power of two, >=2).
- LAT, 2, cycles from an entry reaching queue head to its data_ok (>=1).

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- data_req  in  1  master request valid
- data_wr  in  1  1=write, 0=read
- data_size  in  2  0=byte, 1=halfword, 2=word
- data_addr  in  32  byte address
- data_wdata  in  32  write data, lane-aligned to the address
- data_addr_ok  out  1  request accepted this cycle
- data_rdata  out  32  read word, valid only with data_ok
- data_data_ok  out  1  completion pulse, one per accepted request
- busy  in  1  test back-pressure; forces data_addr_ok=0
- err  out  1  sticky illegal-size/alignment flag

Behaviour:
- Reset: data_addr_ok=0, data_data_ok=0, data_rdata=0, err=0; queue emptied; head counter=0. Memory contents not reset. Reset mid-operation discards all outstanding entries; no data_ok for them.
- Accept: data_addr_ok = data_req && !busy && count<DEPTH (combinational). Not a function of a same-cycle pop, so a full queue refuses even while popping. Handshake at the edge where req&&addr_ok; {wr,size,addr,wdata} pushed.
- Completion: head counter counts cycles with head valid. data_data_ok=1 when head valid && cnt==LAT-1; entry popped and cnt cleared at that edge. LAT=1, empty queue: accept in cycle c gives data_ok in cycle c+1. Throughput is one completion per LAT cycles.
- Simultaneous push and pop is allowed; count is unchanged.
- Index: addr[ADDR_BITS+1:2]. Upper bits ignored (aliasing).
- Read: data_rdata = full aligned word at the head index during the data_ok cycle, else 0. The master extracts lanes.
- Write strobes:
  - size0: byte lane addr[1:0].
  - size1: lanes {addr[1],0} and {addr[1],1}; requires addr[0]=0.
  - size2: all four lanes; requires addr[1:0]=0.
  - Memory is updated at the edge ending the data_ok cycle.
- Illegal size=3 or misaligned half/word: no memory write, data_ok still issued (rdata = aligned word for reads), err set until rst.
- Ordering: all requests complete in acceptance order, so a read queued behind a write to the same word returns the written data.
- wr/size/addr/wdata are sampled only at handshake; changes while waiting are don't-care.

Decomposition:
- Package sram_like_pkg:
  - SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2.
  - Request-entry struct {wr, size, addr, wdata} (67 bits).
  - Function size_addr_to_strb returning a 4-bit strobe plus an illegal bit.
- One sub-module: resp_req_fifo, a synchronous DEPTH-entry FIFO with count/full/empty, first-word-fall-through head.

Test Plan:
- LAT=1, write word 0xDEADBEEF @0x100, then read @0x100 back-to-back → addr_ok both cycles; data_ok in consecutive cycles; read rdata=0xDEADBEEF.
- Byte write 0xAA @0x101 (wdata=0x0000AA00) over 0x11223344 → subsequent word read @0x100 returns 0x1122AA44; halfword 0x5566 @0x102 (wdata=0x55660000) → 0x5566AA44.
- DEPTH=4, LAT=4, hold req 6 cycles → exactly 4 addr_ok, then addr_ok=0 until first data_ok pops; data_ok spaced 4 cycles, in order.
- busy=1 for 3 cycles with req held → addr_ok low throughout, accepted on the first cycle busy=0.
- Halfword write @0x103 → no memory change, data_ok issued, err=1 and stays 1 until rst.
- rst asserted with 3 reads outstanding → no further data_ok; queue empty; next request accepted with data_ok after LAT cycles.
